// File: rtl/eco32f_wb_pkg.sv
// Shared Wishbone constants, FSM encoding and the burst wrap-increment helper
// for the eco32f data-bus RAM responder.
package eco32f_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    // The access itself is taken on the transition out of IDLE or WAIT,
    // so it needs no state of its own.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ACK   = 2'd2,
        ST_BURST = 2'd3
    } wbs_state_e;

    // Next word index of a burst: the low bits selected by bte roll over
    // inside their window, the upper bits stay put. Linear wraps at the RAM end.
    function automatic logic [31:0] next_word(input logic [31:0] idx,
                                              input logic [1:0]  bte,
                                              input int          aw);
        logic [31:0] mask;
        case (bte)
            BTE_WRAP4:  mask = 32'd3;
            BTE_WRAP8:  mask = 32'd7;
            BTE_WRAP16: mask = 32'd15;
            default:    mask = (32'd1 << aw) - 32'd1;
        endcase
        return (idx & ~mask) | ((idx + 32'd1) & mask);
    endfunction

endpackage

// File: rtl/eco32f_spram_be.sv
// Single-port synchronous RAM, 32-bit words with four byte write enables and
// a registered read port whose output register clears on reset.
module eco32f_spram_be #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/eco32f_wb_ram_slave.sv
// Wishbone B3 data-side RAM responder: classic accesses and incrementing wrap bursts.
// Optional address decode with error response when ECO32F_WBS_RAM_ERR_EN is defined.
module eco32f_wb_ram_slave
    import eco32f_wb_pkg::*;
#(
    parameter int          AW          = 12,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [2:0]  wbs_cti_i,
    input  logic [1:0]  wbs_bte_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        wbs_rty_o
);

    localparam logic [3:0] WS_L = 4'(WAIT_STATES);

    wbs_state_e    state_reg, state_next;
    logic          ack_reg, ack_next;
    logic          err_reg, err_next;
    logic [3:0]    wait_cnt_reg, wait_cnt_next;
    logic [AW-1:0] burst_adr_reg, burst_adr_next;

    logic          request;
    logic          addr_ok;
    logic          do_access;
    logic [AW-1:0] adr_word;
    logic          ram_re;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic          unused_ok;

    assign adr_word = wbs_adr_i[AW+1:2];
    assign request  = wbs_cyc_i & wbs_stb_i & ~ack_reg;

`ifdef ECO32F_WBS_RAM_ERR_EN
    assign addr_ok = (wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
`else
    assign addr_ok = 1'b1;
`endif
    assign unused_ok = ^{wbs_adr_i, BASE_ADDR};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            ack_reg       <= 1'b0;
            err_reg       <= 1'b0;
            wait_cnt_reg  <= '0;
            burst_adr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            ack_reg       <= ack_next;
            err_reg       <= err_next;
            wait_cnt_reg  <= wait_cnt_next;
            burst_adr_reg <= burst_adr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ack_next       = 1'b0;
        err_next       = 1'b0;
        wait_cnt_next  = wait_cnt_reg;
        burst_adr_next = burst_adr_reg;
        do_access      = 1'b0;
        ram_re         = 1'b0;
        ram_we         = 4'b0000;
        ram_addr       = adr_word;

        case (state_reg)
            ST_IDLE: begin
                wait_cnt_next = '0;
                if (request) begin
                    if (WAIT_STATES == 0) begin
                        do_access = 1'b1;
                    end else begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (!(wbs_cyc_i && wbs_stb_i)) begin
                    state_next    = ST_IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == WS_L) begin
                    do_access = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end
            ST_ACK: begin
                // The dropped-ack cycle that closes a classic handshake.
                state_next = ST_IDLE;
            end
            ST_BURST: begin
                if (!wbs_cyc_i || !wbs_stb_i || wbs_cti_i == CTI_EOB) begin
                    state_next = ST_IDLE;
                end else begin
                    ram_re         = 1'b1;
                    ram_addr       = burst_adr_reg;
                    ack_next       = 1'b1;
                    burst_adr_next = AW'(next_word(32'(burst_adr_reg), wbs_bte_i, AW));
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (do_access) begin
            wait_cnt_next = '0;
            if (!addr_ok) begin
                err_next   = 1'b1;
                state_next = ST_IDLE;
            end else if (wbs_we_i) begin
                // Writes never burst; an INCR write is answered like a classic one.
                ram_we     = wbs_sel_i;
                ack_next   = 1'b1;
                state_next = ST_ACK;
            end else begin
                ram_re   = 1'b1;
                ack_next = 1'b1;
                if (wbs_cti_i == CTI_INCR) begin
                    state_next     = ST_BURST;
                    burst_adr_next = AW'(next_word(32'(adr_word), wbs_bte_i, AW));
                end else begin
                    state_next = ST_ACK;
                end
            end
        end
    end

    eco32f_spram_be #(.AW(AW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wbs_dat_i),
        .rdata (wbs_dat_o)
    );

    assign wbs_ack_o = ack_reg;
    assign wbs_err_o = err_reg;
    assign wbs_rty_o = 1'b0;

endmodule
